// File: rtl/dso100fb_unpack.sv
// ---------------------------------------------------------------------------
// dso100fb_unpack
// Unpacks 32-bit framebuffer beats into 16-bit RGB565 pixels for the video
// output path. Each beat carries two pixels: low halfword first, then high.
//
// State table
//   state    | meaning
//   ST_IDLE  | no frame active; beats refused, pixel requests get BLANK_COLOR
//   ST_RUN   | frame active; beats buffered, pixel requests served from FIFO
//   ST_DRAIN | previous frame resynced; beats discarded until TLAST seen
//
// Ports
//   CLK, RST             clock (rising edge), async active-high reset
//   S_TDATA/TVALID/TLAST/TREADY  framebuffer read-data stream (slave side)
//   FRAME_START          one-cycle frame-start pulse from video timing
//   PIX_REQ              pixel request, at most one per cycle
//   PIX_DATA             registered pixel, valid the cycle after PIX_REQ
//   UNDERFLOW, SYNC_ERR  sticky error flags, cleared by FLAG_CLR
// ---------------------------------------------------------------------------
module dso100fb_unpack #(
    parameter logic [15:0] BLANK_COLOR = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] S_TDATA,
    input  logic        S_TVALID,
    input  logic        S_TLAST,
    output logic        S_TREADY,
    input  logic        FRAME_START,
    input  logic        PIX_REQ,
    output logic [15:0] PIX_DATA,
    output logic        UNDERFLOW,
    output logic        SYNC_ERR,
    input  logic        FLAG_CLR
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [32:0] mem_q [2];
    logic [32:0] mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        phase_q, phase_d;
    logic        last_seen_q, last_seen_d;
    logic [15:0] pix_data_q, pix_data_d;
    logic        underflow_q, underflow_d;
    logic        sync_err_q, sync_err_d;

    logic        beat_acc;
    logic        fifo_empty;
    logic [32:0] head;
    logic        serve;
    logic        pop;
    logic        push;
    logic        flush;
    logic        stream_done;
    logic        uf_set;
    logic        se_set;

    // Ready depends only on registered state. Once the TLAST beat has been
    // accepted in RUN nothing more is taken until the next RUN entry.
    always_comb begin
        S_TREADY = 1'b0;
        case (state_q)
            ST_RUN:   S_TREADY = (count_q != 2'd2) && !last_seen_q;
            ST_DRAIN: S_TREADY = 1'b1;
            default:  S_TREADY = 1'b0;
        endcase
    end

    assign beat_acc   = S_TVALID && S_TREADY;
    assign fifo_empty = (count_q == 2'd0);
    assign head       = mem_q[rd_ptr_q];

    // FRAME_START takes priority over a coincident pixel request.
    assign serve = (state_q == ST_RUN) && PIX_REQ && !FRAME_START && !fifo_empty;
    assign pop   = serve && phase_q;
    assign push  = (state_q == ST_RUN) && !FRAME_START && beat_acc;

    // The old transfer is already complete if its TLAST was accepted earlier
    // or is being accepted right now; then there is nothing left to drain.
    assign stream_done = last_seen_q || (beat_acc && S_TLAST);

    assign flush = ((state_q == ST_IDLE) && FRAME_START)
                || ((state_q == ST_RUN) && FRAME_START)
                || ((state_q == ST_DRAIN) && beat_acc && S_TLAST);

    assign uf_set = (state_q == ST_RUN) && PIX_REQ && !FRAME_START && fifo_empty;
    assign se_set = (state_q == ST_RUN) && FRAME_START;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (FRAME_START) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (FRAME_START) begin
                    state_d = stream_done ? ST_RUN : ST_DRAIN;
                end else if (pop && head[32]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (beat_acc && S_TLAST) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath / output logic
    always_comb begin
        mem_d[0]    = mem_q[0];
        mem_d[1]    = mem_q[1];
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        phase_d     = phase_q;
        last_seen_d = last_seen_q;
        pix_data_d  = pix_data_q;

        if (flush) begin
            wr_ptr_d    = 1'b0;
            rd_ptr_d    = 1'b0;
            count_d     = 2'd0;
            phase_d     = 1'b0;
            last_seen_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {S_TLAST, S_TDATA};
                wr_ptr_d        = ~wr_ptr_q;
                if (S_TLAST) last_seen_d = 1'b1;
            end
            if (pop) rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            if (serve) phase_d = ~phase_q;
        end

        if (PIX_REQ) begin
            if (serve) begin
                pix_data_d = phase_q ? head[31:16] : head[15:0];
            end else begin
                pix_data_d = BLANK_COLOR;
            end
        end

        // A set event in the same cycle as FLAG_CLR wins.
        underflow_d = uf_set || (underflow_q && !FLAG_CLR);
        sync_err_d  = se_set || (sync_err_q && !FLAG_CLR);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            phase_q     <= 1'b0;
            last_seen_q <= 1'b0;
            pix_data_q  <= BLANK_COLOR;
            underflow_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            mem_q[0]    <= mem_d[0];
            mem_q[1]    <= mem_d[1];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            phase_q     <= phase_d;
            last_seen_q <= last_seen_d;
            pix_data_q  <= pix_data_d;
            underflow_q <= underflow_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign PIX_DATA  = pix_data_q;
    assign UNDERFLOW = underflow_q;
    assign SYNC_ERR  = sync_err_q;

endmodule

// File: tb/tb_dso100fb_unpack.sv
// ---------------------------------------------------------------------------
// tb_dso100fb_unpack
// Directed bench: a table of single-cycle vectors with hand-computed results,
// followed by hand-written multi-cycle sequences (streaming, resync, reset).
// ---------------------------------------------------------------------------
module tb_dso100fb_unpack;

    logic        CLK;
    logic        RST;
    logic [31:0] S_TDATA;
    logic        S_TVALID;
    logic        S_TLAST;
    logic        S_TREADY;
    logic        FRAME_START;
    logic        PIX_REQ;
    logic [15:0] PIX_DATA;
    logic        UNDERFLOW;
    logic        SYNC_ERR;
    logic        FLAG_CLR;

    int checks = 0;
    int errors = 0;

    dso100fb_unpack dut (
        .CLK         (CLK),
        .RST         (RST),
        .S_TDATA     (S_TDATA),
        .S_TVALID    (S_TVALID),
        .S_TLAST     (S_TLAST),
        .S_TREADY    (S_TREADY),
        .FRAME_START (FRAME_START),
        .PIX_REQ     (PIX_REQ),
        .PIX_DATA    (PIX_DATA),
        .UNDERFLOW   (UNDERFLOW),
        .SYNC_ERR    (SYNC_ERR),
        .FLAG_CLR    (FLAG_CLR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        fs;
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        req;
        logic        clr;
        logic        e_rdy;
        logic [15:0] e_pix;
        logic        e_uf;
        logic        e_se;
    } vec_t;

    vec_t vecs [26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        S_TDATA     = '0;
        S_TVALID    = 1'b0;
        S_TLAST     = 1'b0;
        FRAME_START = 1'b0;
        PIX_REQ     = 1'b0;
        FLAG_CLR    = 1'b0;
    endtask

    task automatic frame_start();
        FRAME_START = 1'b1;
        step();
        FRAME_START = 1'b0;
    endtask

    task automatic pix_req();
        PIX_REQ = 1'b1;
        step();
        PIX_REQ = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        logic ok;
        logic r;
        ok       = 1'b0;
        S_TVALID = 1'b1;
        S_TDATA  = d;
        S_TLAST  = l;
        for (int i = 0; i < 20 && !ok; i++) begin
            r = S_TREADY;
            step();
            if (r) ok = 1'b1;
        end
        S_TVALID = 1'b0;
        S_TLAST  = 1'b0;
        chk("beat_accept", {31'd0, ok}, 32'd1);
    endtask

    function automatic logic [31:0] stream_word(input int i);
        logic [15:0] lo;
        lo = 16'hA000 + 16'(2 * i);
        return {lo + 16'd1, lo};
    endfunction

    function automatic logic [31:0] resync_word(input int i);
        return {16'hD100 + 16'(i), 16'hD000 + 16'(i)};
    endfunction

    initial begin
        clear_inputs();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_pix",   {16'd0, PIX_DATA}, 32'h0000);
        chk("rst_ready", {31'd0, S_TREADY}, 32'd0);
        chk("rst_uf",    {31'd0, UNDERFLOW}, 32'd0);
        chk("rst_se",    {31'd0, SYNC_ERR}, 32'd0);
        RST = 1'b0;

        //           fs  v   data           l   req clr  rdy  pix       uf  se
        vecs[0]  = '{0, 0, 32'h0,          0,  1,  0,   0, 16'h0000, 0, 0};
        vecs[1]  = '{1, 0, 32'h0,          0,  0,  0,   0, 16'h0000, 0, 0};
        vecs[2]  = '{0, 1, 32'h2222_1111,  0,  0,  0,   1, 16'h0000, 0, 0};
        vecs[3]  = '{0, 1, 32'h4444_3333,  1,  0,  0,   1, 16'h0000, 0, 0};
        vecs[4]  = '{0, 0, 32'h0,          0,  1,  0,   0, 16'h1111, 0, 0};
        vecs[5]  = '{0, 0, 32'h0,          0,  1,  0,   0, 16'h2222, 0, 0};
        vecs[6]  = '{0, 0, 32'h0,          0,  1,  0,   0, 16'h3333, 0, 0};
        vecs[7]  = '{0, 0, 32'h0,          0,  1,  0,   0, 16'h4444, 0, 0};
        vecs[8]  = '{0, 0, 32'h0,          0,  1,  0,   0, 16'h0000, 0, 0};
        vecs[9]  = '{1, 0, 32'h0,          0,  0,  0,   0, 16'h0000, 0, 0};
        vecs[10] = '{0, 0, 32'h0,          0,  1,  0,   1, 16'h0000, 1, 0};
        vecs[11] = '{0, 0, 32'h0,          0,  1,  1,   1, 16'h0000, 1, 0};
        vecs[12] = '{0, 0, 32'h0,          0,  0,  1,   1, 16'h0000, 0, 0};
        vecs[13] = '{0, 1, 32'hBBBB_AAAA,  0,  0,  0,   1, 16'h0000, 0, 0};
        vecs[14] = '{0, 0, 32'h0,          0,  1,  0,   1, 16'hAAAA, 0, 0};
        vecs[15] = '{1, 0, 32'h0,          0,  1,  0,   1, 16'h0000, 0, 1};
        vecs[16] = '{0, 1, 32'h1234_5678,  0,  1,  0,   1, 16'h0000, 0, 1};
        vecs[17] = '{0, 1, 32'h9999_9999,  1,  0,  0,   1, 16'h0000, 0, 1};
        vecs[18] = '{1, 0, 32'h0,          0,  0,  1,   1, 16'h0000, 0, 1};
        vecs[19] = '{0, 0, 32'h0,          0,  0,  1,   1, 16'h0000, 0, 0};
        vecs[20] = '{1, 0, 32'h0,          0,  0,  0,   1, 16'h0000, 0, 0};
        vecs[21] = '{0, 1, 32'h0,          1,  0,  0,   1, 16'h0000, 0, 0};
        vecs[22] = '{0, 1, 32'h5678_1234,  1,  0,  0,   1, 16'h0000, 0, 0};
        vecs[23] = '{0, 0, 32'h0,          0,  1,  0,   0, 16'h1234, 0, 0};
        vecs[24] = '{0, 0, 32'h0,          0,  1,  0,   0, 16'h5678, 0, 0};
        vecs[25] = '{0, 0, 32'h0,          0,  0,  0,   0, 16'h5678, 0, 0};

        for (int i = 0; i < 26; i++) begin
            FRAME_START = vecs[i].fs;
            S_TVALID    = vecs[i].v;
            S_TDATA     = vecs[i].d;
            S_TLAST     = vecs[i].l;
            PIX_REQ     = vecs[i].req;
            FLAG_CLR    = vecs[i].clr;
            chk($sformatf("v%0d_ready", i), {31'd0, S_TREADY}, {31'd0, vecs[i].e_rdy});
            step();
            chk($sformatf("v%0d_pix", i), {16'd0, PIX_DATA}, {16'd0, vecs[i].e_pix});
            chk($sformatf("v%0d_uf", i), {31'd0, UNDERFLOW}, {31'd0, vecs[i].e_uf});
            chk($sformatf("v%0d_se", i), {31'd0, SYNC_ERR}, {31'd0, vecs[i].e_se});
        end
        clear_inputs();

        // Continuous streaming: TVALID always high, PIX_REQ every cycle.
        begin
            int          n_words;
            int          sent;
            int          npix;
            int          occ;
            int          cyc;
            int          ready_full;
            int          model_uf;
            logic        hs;
            logic        served;
            logic        popped;
            logic [31:0] w;
            logic [15:0] exp_pix;
            n_words    = 16;
            sent       = 0;
            npix       = 0;
            occ        = 0;
            cyc        = 0;
            ready_full = 0;
            model_uf   = 0;
            frame_start();
            while (npix < 2 * n_words && cyc < 300) begin
                S_TVALID = (sent < n_words);
                S_TDATA  = stream_word(sent);
                S_TLAST  = (sent == n_words - 1);
                PIX_REQ  = (cyc >= 1) && (npix < 2 * n_words);
                hs       = S_TVALID && S_TREADY;
                if (S_TREADY && occ == 2) ready_full++;
                served   = PIX_REQ && (occ > 0);
                popped   = served && (npix % 2 == 1);
                if (PIX_REQ && occ == 0) model_uf++;
                w        = stream_word(npix / 2);
                exp_pix  = (npix % 2 == 1) ? w[31:16] : w[15:0];
                step();
                if (served) begin
                    chk($sformatf("stream_pix%0d", npix), {16'd0, PIX_DATA}, {16'd0, exp_pix});
                    npix++;
                end
                occ = occ + (hs ? 1 : 0) - (popped ? 1 : 0);
                if (hs) sent++;
                cyc++;
            end
            clear_inputs();
            chk("stream_all_pixels", npix, 2 * n_words);
            chk("stream_all_beats", sent, n_words);
            chk("stream_ready_when_full", ready_full, 0);
            chk("stream_model_uf", model_uf, 0);
            chk("stream_underflow", {31'd0, UNDERFLOW}, 32'd0);
            chk("stream_idle_ready", {31'd0, S_TREADY}, 32'd0);
        end

        // Resync: FRAME_START after 3 of 8 beats.
        begin
            logic [31:0] b;
            frame_start();
            send_beat(resync_word(0), 1'b0);
            send_beat(resync_word(1), 1'b0);
            b = resync_word(0);
            pix_req();
            chk("rs_b0_lo", {16'd0, PIX_DATA}, {16'd0, b[15:0]});
            pix_req();
            chk("rs_b0_hi", {16'd0, PIX_DATA}, {16'd0, b[31:16]});
            send_beat(resync_word(2), 1'b0);
            frame_start();
            chk("rs_sync_err", {31'd0, SYNC_ERR}, 32'd1);
            for (int i = 3; i < 7; i++) send_beat(resync_word(i), 1'b0);
            send_beat(resync_word(7), 1'b1);
            chk("rs_sync_err_held", {31'd0, SYNC_ERR}, 32'd1);
            send_beat(resync_word(8), 1'b1);
            b = resync_word(8);
            pix_req();
            chk("rs_first_pix", {16'd0, PIX_DATA}, {16'd0, b[15:0]});
            pix_req();
            chk("rs_second_pix", {16'd0, PIX_DATA}, {16'd0, b[31:16]});
            chk("rs_underflow", {31'd0, UNDERFLOW}, 32'd0);
            FLAG_CLR = 1'b1;
            step();
            FLAG_CLR = 1'b0;
            chk("rs_flag_clr", {31'd0, SYNC_ERR}, 32'd0);
        end

        // Reset mid-frame with two words buffered and a half-consumed head.
        begin
            frame_start();
            pix_req();
            chk("mr_uf_set", {31'd0, UNDERFLOW}, 32'd1);
            send_beat(32'h6666_5555, 1'b0);
            send_beat(32'h8888_7777, 1'b0);
            chk("mr_full_ready", {31'd0, S_TREADY}, 32'd0);
            pix_req();
            chk("mr_pix_before", {16'd0, PIX_DATA}, 32'h5555);
            #3;
            RST = 1'b1;
            #1;
            chk("mr_rst_pix",   {16'd0, PIX_DATA}, 32'h0000);
            chk("mr_rst_ready", {31'd0, S_TREADY}, 32'd0);
            chk("mr_rst_uf",    {31'd0, UNDERFLOW}, 32'd0);
            chk("mr_rst_se",    {31'd0, SYNC_ERR}, 32'd0);
            step();
            RST      = 1'b0;
            S_TVALID = 1'b1;
            S_TDATA  = 32'h1234_ABCD;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("mr_idle_ready%0d", i), {31'd0, S_TREADY}, 32'd0);
                step();
            end
            S_TVALID = 1'b0;
            frame_start();
            chk("mr_run_ready", {31'd0, S_TREADY}, 32'd1);
            send_beat(32'h2BCD_1BCD, 1'b1);
            pix_req();
            chk("mr_new_lo", {16'd0, PIX_DATA}, 32'h1BCD);
            pix_req();
            chk("mr_new_hi", {16'd0, PIX_DATA}, 32'h2BCD);
            chk("mr_uf_end", {31'd0, UNDERFLOW}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
